l2_line_adaptor: RTL and testbench

//  Memory-side responder for the L2 cache line port: serves 256-bit line reads/writes issued by the L2
//  (pmem_address/pmem_rdata/pmem_wdata) by converting each into a burst of 64-bit beats on the

---
 rtl/l2_line_adaptor.sv | 106 ++++++++++
 tb/tb_l2_line_adaptor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_adaptor.sv
// L2 line adaptor: turns one 256-bit L2 line read/write into a
// burst of 64-bit beats on the memory burst port, one transaction at a time.
module l2_line_adaptor #(
    parameter int s_line   = 256,
    parameter int s_burst  = 64,
    parameter int s_offset = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    output logic              resp_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [s_burst-1:0] burst_o,
    input  logic [s_burst-1:0] burst_i,
    input  logic              resp_i
);

    localparam int num_beats = s_line / s_burst;
    localparam int cw        = $clog2(num_beats);
    localparam logic [cw-1:0] last_idx = cw'(num_beats - 1);
    localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t            state;
    logic [cw-1:0]     count;
    logic [s_line-1:0] wr_line;
    logic              last_beat;

    assign last_beat = resp_i && (count == last_idx);

    // Write beat follows the beat counter directly so memory sees the
    // next beat in the cycle after each handshake.
    assign burst_o = write_o ? wr_line[count*s_burst +: s_burst] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            line_o    <= '0;
            wr_line   <= '0;
            address_o <= '0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (write_i) begin
                        address_o <= address_i & line_mask;
                        wr_line   <= line_i;
                        write_o   <= 1'b1;
                        state     <= WR_BURST;
                    end else if (read_i) begin
                        address_o <= address_i & line_mask;
                        read_o    <= 1'b1;
                        state     <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_o[count*s_burst +: s_burst] <= burst_i;
                        count <= count + 1'b1;
                    end
                    if (last_beat) begin
                        count  <= '0;
                        read_o <= 1'b0;
                        resp_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        count <= count + 1'b1;
                    end
                    if (last_beat) begin
                        count   <= '0;
                        write_o <= 1'b0;
                        resp_o  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Bench for l2_line_adaptor: directed table, corner sequences and
// randomized transactions against a beat-counting reference model.
module tb_l2_line_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] model_line;

    l2_line_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [15:0]  pat;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t tbl[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full L2 transaction; data is the write line or the memory's
    // read line (beat k = data[64k +: 64]).
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] data, input logic [15:0] pat,
                           input bit use_rand, input logic [31:0] exp_addr);
        bit is_wr;
        bit go;
        int beats;
        int cyc;
        is_wr = wr;
        beats = 0;
        cyc   = 0;
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = data;
        resp_i    = 1'b0;
        step();
        address_i = $urandom;
        line_i    = {8{$urandom}};
        while (beats < 4 && cyc < 100) begin
            chk("read_o", 256'(read_o), 256'(!is_wr));
            chk("write_o", 256'(write_o), 256'(is_wr));
            chk("address_o", 256'(address_o), 256'(exp_addr));
            chk("resp_o_busy", 256'(resp_o), 256'(0));
            if (is_wr)
                chk("burst_o", 256'(burst_o), 256'(data[64*beats +: 64]));
            if (use_rand)
                go = ($urandom_range(0, 2) != 0);
            else
                go = (cyc < 16) ? pat[cyc] : 1'b1;
            resp_i  = go;
            burst_i = (go && !is_wr) ? data[64*beats +: 64]
                                     : {$urandom, $urandom};
            step();
            if (go) beats++;
            cyc++;
        end
        if (beats < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d beats expected 4", beats);
        end
        resp_i = 1'b0;
        if (!is_wr) model_line = data;
        chk("resp_o_done", 256'(resp_o), 256'(1));
        chk("read_o_done", 256'(read_o), 256'(0));
        chk("write_o_done", 256'(write_o), 256'(0));
        chk("line_o", line_o, model_line);
        read_i  = 1'b0;
        write_i = 1'b0;
        step();
        chk("resp_o_pulse", 256'(resp_o), 256'(0));
        chk("idle_busy", 256'({read_o, write_o}), 256'(0));
    endtask

    initial begin
        logic [255:0] rline;
        logic [255:0] wline;
        logic [31:0]  a;
        bit           r;
        bit           w;

        rline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, rline, 16'hFFFF, 32'h0000_1220};
        tbl[1] = '{1'b0, 1'b1, 32'h8000_003F, wline, 16'hFFFF, 32'h8000_0020};
        tbl[2] = '{1'b1, 1'b0, 32'hDEAD_BEEF, ~rline, 16'hFF59, 32'hDEAD_BEE0};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_0040, ~wline, 16'hFFFF, 32'h0000_0040};
        tbl[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, rline ^ wline, 16'hAAAA,
                   32'hFFFF_FFE0};

        rst = 1'b1;
        address_i = '0;
        read_i = 1'b0;
        write_i = 1'b0;
        line_i = '0;
        burst_i = '0;
        resp_i = 1'b0;
        model_line = '0;
        step();
        step();
        chk("rst_line_o", line_o, 256'(0));
        chk("rst_address_o", 256'(address_o), 256'(0));
        chk("rst_burst_o", 256'(burst_o), 256'(0));
        chk("rst_ctl", 256'({resp_o, read_o, write_o}), 256'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++)
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                    tbl[i].pat, 1'b0, tbl[i].exp_addr);

        // resp_i pulses while idle must not start anything
        for (int i = 0; i < 4; i++) begin
            resp_i  = i[0];
            burst_i = {$urandom, $urandom};
            step();
            chk("idle_resp_ctl", 256'({resp_o, read_o, write_o}), 256'(0));
            chk("idle_line_o", line_o, model_line);
        end
        resp_i = 1'b0;

        // reset after two read beats drops the transaction
        read_i    = 1'b1;
        address_i = 32'h0000_5000;
        step();
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            step();
        end
        rst    = 1'b1;
        resp_i = 1'b0;
        read_i = 1'b0;
        step();
        model_line = '0;
        chk("mid_rst_read_o", 256'(read_o), 256'(0));
        chk("mid_rst_line_o", line_o, 256'(0));
        chk("mid_rst_resp_o", 256'(resp_o), 256'(0));
        rst = 1'b0;
        step();
        chk("post_rst_ctl", 256'({resp_o, read_o, write_o}), 256'(0));
        run_txn(1'b1, 1'b0, 32'h0000_5008, {rline[127:0], wline[127:0]},
                16'hFFFF, 1'b0, 32'h0000_5000);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            if (!r && !w) r = 1'b1;
            run_txn(r, w, a, {8{$urandom}}, 16'h0, 1'b1, a & 32'hFFFF_FFE0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
